alu4bit_bist: RTL and testbench

// - Synthesizable self-test engine for ALU4bit. Acts as the driving end of the ALU interface.
// - Sweeps all {sel,a,b} vectors into the ALU, compares y against an internal golden model,

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_ref_model.sv | 24 ++
 rtl/alu4bit_bist.sv | 108 ++++++++++
 tb/tb_alu4bit_bist.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and BIST state type.
// Used by the self-test engine and any other ALU checker.
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: bitwise AND/OR/XOR/NOT-a, no carry.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu4bit_bist.sv
// Exhaustive self-test sweep for ALU4bit: drives every {sel,a,b}, checks y against
// the reference model, counts mismatches and latches the first failing vector.
module alu4bit_bist
    import alu_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic [1:0]           dut_sel,
    input  logic [WIDTH-1:0]     dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+2:0]   err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH+1:0]   first_fail_vec,
    output logic [WIDTH-1:0]     first_fail_y
);

    localparam int IW = 2*WIDTH + 2;
    localparam int EW = 2*WIDTH + 3;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    bist_state_t      state;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    settle;
    logic [WIDTH-1:0] y_ref;
    logic             sample;
    logic             mismatch;
    logic             last_vec;
    logic [EW-1:0]    err_next;

    // Vector outputs come straight from the index register, so they read 0 outside RUN.
    assign {dut_sel, dut_a, dut_b} = idx;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .sel (dut_sel),
        .a   (dut_a),
        .b   (dut_b),
        .y   (y_ref)
    );

    assign sample   = (state == RUN) && (settle == SETTLE_LAST);
    assign mismatch = sample && (dut_y != y_ref);
    assign last_vec = &idx;
    // Saturating guard; the count cannot exceed the vector total anyway.
    assign err_next = (mismatch && !(&err_count)) ? err_count + EW'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            settle         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            first_fail_y   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        idx            <= '0;
                        settle         <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                        first_fail_y   <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        settle    <= '0;
                        idx       <= idx + IW'(1);
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_vec <= idx;
                            first_fail_y   <= dut_y;
                        end
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end else begin
                        settle <= settle + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4bit_bist.sv
// Bench for alu4bit_bist: behavioural ALU with injectable faults, exhaustive reference
// scoreboard, two engines (SETTLE_CYCLES 1 and 3).
module tb_alu4bit_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] a1, b1, y1, a3, b3, y3, ffy1, ffy3;
    logic [1:0] sel1, sel3;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [10:0] err1, err3;
    logic [9:0]  ffv1, ffv3;

    int   mode = 0;
    logic [3:0] mask [1024];
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] golden(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // mode 0 good, 1 y[0] stuck-at-0, 2 NOT returns b, 3 random per-vector corruption
    function automatic logic [3:0] alu_beh(input logic [1:0] s, input logic [3:0] a,
                                           input logic [3:0] b, input int m, input logic [3:0] mk);
        logic [3:0] g;
        g = golden(s, a, b);
        case (m)
            1: return g & 4'b1110;
            2: return (s == 2'd3) ? b : g;
            3: return g ^ mk;
            default: return g;
        endcase
    endfunction

    assign y1 = alu_beh(sel1, a1, b1, mode, mask[{sel1, a1, b1}]);
    assign y3 = alu_beh(sel3, a3, b3, mode, mask[{sel3, a3, b3}]);

    alu4bit_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_sel(sel1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_vec(ffv1), .first_fail_y(ffy1)
    );

    alu4bit_bist #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .dut_a(a3), .dut_b(b3), .dut_sel(sel3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail_vec(ffv3), .first_fail_y(ffy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: walk every vector through the faulty ALU and compare to the ALU rules.
    task automatic model(input int m, output int errs, output int first, output int fy);
        logic [1:0] s;
        logic [3:0] a, b, y;
        errs = 0; first = -1; fy = 0;
        for (int k = 0; k < 1024; k++) begin
            s = 2'(k >> 8); a = 4'(k >> 4); b = 4'(k);
            y = alu_beh(s, a, b, m, mask[k]);
            if (y != golden(s, a, b)) begin
                errs++;
                if (first < 0) begin first = k; fy = int'(y); end
            end
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_busy"}, 32'(busy1 | busy3), 0);
        chk({tag, "_done"}, 32'(done1 | done3), 0);
        chk({tag, "_pass"}, 32'(pass1 | pass3), 0);
        chk({tag, "_err"}, 32'(err1 | err3), 0);
        chk({tag, "_fv"}, 32'(fv1 | fv3), 0);
        chk({tag, "_ffv"}, 32'(ffv1 | ffv3), 0);
        chk({tag, "_ffy"}, 32'(ffy1 | ffy3), 0);
        chk({tag, "_vec"}, 32'({sel1, a1, b1} | {sel3, a3, b3}), 0);
    endtask

    // Called at posedge+1. Starts a sweep on the S=s engine and checks it end to end.
    task automatic run_check(input int s, input int m, input int repulse, input int rst_at, input string tag);
        int n, busy_n, vec_bad, e_err, e_first, e_fy, limit;
        bit fin;
        logic b_busy, b_done;
        logic [9:0] vec;
        mode = m;
        model(m, e_err, e_first, e_fy);
        if (s == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;              // E0
        start1 = 1'b0; start3 = 1'b0;
        n = 0; busy_n = 0; vec_bad = 0; fin = 0; limit = 1024*s + 16;
        while (!fin && n < limit) begin
            b_busy = (s == 1) ? busy1 : busy3;
            vec    = (s == 1) ? {sel1, a1, b1} : {sel3, a3, b3};
            if (b_busy) busy_n++;
            if (b_busy && int'(vec) != n / s) vec_bad++;
            if (n == rst_at) begin
                rst_n = 1'b0; #1;
                zero_check({tag, "_async_rst"});
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                zero_check({tag, "_idle_after_rst"});
                return;
            end
            if (n == repulse - 1) begin
                if (s == 1) start1 = 1'b1; else start3 = 1'b1;
            end
            @(posedge clk); #1;
            start1 = 1'b0; start3 = 1'b0;
            n++;
            b_done = (s == 1) ? done1 : done3;
            if (b_done) fin = 1;
        end
        chk({tag, "_done_seen"}, 32'(fin), 1);
        chk({tag, "_done_cycle"}, 32'(n), 32'(1024*s));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(1024*s));
        chk({tag, "_vector_order"}, 32'(vec_bad), 0);
        if (s == 1) begin
            chk({tag, "_busy_end"}, 32'(busy1), 0);
            chk({tag, "_err"}, 32'(err1), 32'(e_err));
            chk({tag, "_pass"}, 32'(pass1), 32'(e_err == 0));
            chk({tag, "_fv"}, 32'(fv1), 32'(e_first >= 0));
            chk({tag, "_ffv"}, 32'(ffv1), (e_first >= 0) ? 32'(e_first) : 0);
            chk({tag, "_ffy"}, 32'(ffy1), 32'(e_fy));
            chk({tag, "_vec_idle"}, 32'({sel1, a1, b1}), 0);
        end else begin
            chk({tag, "_busy_end"}, 32'(busy3), 0);
            chk({tag, "_err"}, 32'(err3), 32'(e_err));
            chk({tag, "_pass"}, 32'(pass3), 32'(e_err == 0));
            chk({tag, "_fv"}, 32'(fv3), 32'(e_first >= 0));
            chk({tag, "_ffv"}, 32'(ffv3), (e_first >= 0) ? 32'(e_first) : 0);
            chk({tag, "_ffy"}, 32'(ffy3), 32'(e_fy));
            chk({tag, "_vec_idle"}, 32'({sel3, a3, b3}), 0);
        end
        // results must hold in DONE
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_hold"}, 32'((s == 1) ? done1 : done3), 1);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++)
            mask[k] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        #2;
        zero_check("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        zero_check("idle");

        run_check(1, 0, -1, -1, "good_s1");
        idle_gap();
        run_check(1, 1, -1, -1, "stuck0");
        chk("stuck0_err_abs", 32'(err1), 512);
        chk("stuck0_ffv_abs", 32'(ffv1), 32'h011);
        chk("stuck0_ffy_abs", 32'(ffy1), 0);
        idle_gap();
        run_check(1, 2, -1, -1, "not_b");
        idle_gap();
        run_check(1, 3, -1, -1, "rand_fault");
        idle_gap();
        run_check(1, 0, 100, -1, "repulse");
        idle_gap();
        run_check(1, 0, -1, 500, "mid_reset");
        run_check(1, 0, -1, -1, "after_reset");
        idle_gap();
        run_check(3, 0, -1, -1, "good_s3");
        idle_gap();
        run_check(3, 0, -1, -1, "good_s3_again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
